// File: rtl/piso_bit_serializer_pkg.sv
// Shared types and constants for the sequence-detector feed path.
// Holds the serializer state encoding and the width sanity helper.
package pkg_seq_common;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic IDLE_BIT_DEF = 1'b0;

  function automatic bit width_ok(input int w);
    return w >= 2;
  endfunction

endpackage

// File: rtl/piso_bit_serializer_if.sv
// Load handshake and serial stream bundle for piso_bit_serializer.
// master = word producer / stream consumer, slave = serializer.
interface piso_bit_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_done;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  frame_done
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output ser_out,
    output ser_valid,
    output frame_done
  );

endinterface

// File: rtl/piso_bit_serializer_shift_reg.sv
// Load/shift register; ser_tap is the bit the register presents
// after the coming edge, so the caller can register it in step.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_tap
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_en) begin
      sr_d = load_data;
    end else if (shift_en) begin
      sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_tap = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in serial-out word serializer feeding detector input x.
// Gapless back-to-back words unless GAP_CYCLES idles are requested.
module piso_bit_serializer
  import pkg_seq_common::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_BIT   = IDLE_BIT_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  piso_bit_serializer_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("piso_bit_serializer: WIDTH must be >= 2");
  end

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] bit_cnt_q;
  logic [CW-1:0] bit_cnt_d;
  logic          ser_out_q;
  logic          ser_out_d;
  logic          ser_valid_q;
  logic          ser_valid_d;
  logic          frame_done_q;
  logic          frame_done_d;

  logic load_ready;
  logic accept;
  logic last;
  logic gap_done;
  logic ser_tap;

  assign last = (state_q == SHIFT)
             && (bit_cnt_q == LAST);

  // Gapless mode reopens the handshake on the last bit
  assign load_ready = rst_n
                   && ((state_q == IDLE)
                   || ((GAP_CYCLES == 0) && last));

  assign accept = bus.load_valid && load_ready;

  if (GAP_CYCLES > 0) begin : g_gap
    localparam int GW = $clog2(GAP_CYCLES + 1);

    logic [GW-1:0] gap_cnt_q;
    logic [GW-1:0] gap_cnt_d;

    always_comb begin
      gap_cnt_d = '0;
      if (state_q == GAP) begin
        gap_cnt_d = gap_cnt_q + GW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        gap_cnt_q <= '0;
      end else begin
        gap_cnt_q <= gap_cnt_d;
      end
    end

    assign gap_done = (gap_cnt_q == GW'(GAP_CYCLES - 1));
  end else begin : g_no_gap
    assign gap_done = 1'b1;
  end

  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (accept),
    .shift_en (state_q == SHIFT),
    .load_data(bus.load_data),
    .ser_tap  (ser_tap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      ser_out_q    <= IDLE_BIT;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (!last) begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end else begin
          bit_cnt_d = '0;
          if (accept) begin
            state_d = SHIFT;
          end else if (GAP_CYCLES > 0) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values to show the current bit
  always_comb begin
    ser_out_d    = IDLE_BIT;
    ser_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (state_d == SHIFT) begin
      ser_out_d    = ser_tap;
      ser_valid_d  = 1'b1;
      frame_done_d = (bit_cnt_d == LAST);
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: ch0 MSB-first gapless, ch1 LSB-first
// with a 2-cycle gap, each checked against a queue-based stream model.
module tb_piso_bit_serializer;

  typedef struct packed {
    logic       b;
    logic       v;
    logic       fd;
    logic [1:0] kind;
  } item_t;

  localparam logic [1:0] K_IDLE = 2'd0;
  localparam logic [1:0] K_BIT  = 2'd1;
  localparam logic [1:0] K_GAP  = 2'd2;

  logic       clk;
  logic       rst_n;
  logic       lv [2];
  logic [7:0] ld [2];
  logic [1:0] rdy;
  logic [1:0] so;
  logic [1:0] sv;
  logic [1:0] fdv;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam bit MSB  = (g == 0);
    localparam int GAPC = (g == 0) ? 0 : 2;

    piso_bit_serializer_if #(.WIDTH(8)) bus ();

    piso_bit_serializer #(
      .WIDTH     (8),
      .MSB_FIRST (MSB),
      .GAP_CYCLES(GAPC),
      .IDLE_BIT  (1'b0)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    assign bus.load_valid = lv[g];
    assign bus.load_data  = ld[g];
    assign rdy[g] = bus.load_ready;
    assign so[g]  = bus.ser_out;
    assign sv[g]  = bus.ser_valid;
    assign fdv[g] = bus.frame_done;

    item_t q[$];
    item_t cur;
    bit    live = 1'b0;

    function automatic logic m_rdy();
      if (!rst_n || q.size() != 0) return 1'b0;
      if (cur.kind == K_IDLE) return 1'b1;
      return (cur.kind == K_BIT) && cur.fd && (GAPC == 0);
    endfunction

    always @(posedge clk) begin : mdl
      item_t it;
      logic  acc;
      if (!rst_n) begin
        q.delete();
        cur  = '0;
        live = 1'b1;
      end else if (live) begin
        acc = lv[g] && m_rdy();
        if (acc) begin
          for (int k = 0; k < 8; k++) begin
            it.b    = MSB ? ld[g][7-k] : ld[g][k];
            it.v    = 1'b1;
            it.fd   = (k == 7);
            it.kind = K_BIT;
            q.push_back(it);
          end
          for (int k = 0; k < GAPC; k++) begin
            it      = '0;
            it.kind = K_GAP;
            q.push_back(it);
          end
        end
        if (q.size() != 0) cur = q.pop_front();
        else cur = '0;
      end
    end

    always @(negedge clk) begin
      if (live) begin
        check($sformatf("ch%0d load_ready", g), 32'(rdy[g]), 32'(m_rdy()));
        check($sformatf("ch%0d ser_valid", g), 32'(sv[g]), 32'(cur.v));
        check($sformatf("ch%0d ser_out", g), 32'(so[g]), 32'(cur.b));
        check($sformatf("ch%0d frame_done", g), 32'(fdv[g]), 32'(cur.fd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    logic [7:0]  w;
    logic [7:0]  fm;
    logic [15:0] s;
    logic [15:0] vm;
    logic [15:0] rm;
    logic [18:0] bv;
    logic [18:0] vv;
    logic [2:0]  win;
    int          hits;
    int          nv;
    int          ones;
    int          nfd;

    rst_n = 1'b0;
    lv[0] = 1'b1;
    lv[1] = 1'b1;
    ld[0] = 8'hA5;
    ld[1] = 8'h3C;

    // 1: reset with valid held
    tick();
    tick();
    @(negedge clk);
    check("t1 ready in reset", 32'(rdy[0]), 32'd0);
    check("t1 valid in reset", 32'(sv[0]), 32'd0);
    check("t1 ser_out in reset", 32'(so[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    lv[0] = 1'b0;
    lv[1] = 1'b0;
    #1;
    check("t1 ready after release", 32'(rdy[0]), 32'd1);
    check("t1 ready ch1 after release", 32'(rdy[1]), 32'd1);

    // 2: single word A5, MSB first
    tick();
    ld[0] = 8'hA5;
    lv[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      w[7-k] = so[0];
      fm[k]  = fdv[0];
    end
    check("t2 bits", 32'(w), 32'h0000_00A5);
    check("t2 frame_done mask", 32'(fm), 32'h0000_0080);
    @(negedge clk);
    check("t2 idle after word", 32'(sv[0]), 32'd0);

    // 3: back-to-back 05 then 40
    tick();
    ld[0] = 8'h05;
    lv[0] = 1'b1;
    tick();
    ld[0] = 8'h40;
    win  = '0;
    hits = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      s[15-k] = so[0];
      vm[k]   = sv[0];
      rm[k]   = rdy[0];
      win     = {win[1:0], so[0]};
      if (k >= 2 && win == 3'b101) hits++;
      if (k == 7) begin
        tick();
        lv[0] = 1'b0;
      end
    end
    check("t3 bits", 32'(s), 32'h0000_0540);
    check("t3 valid mask", 32'(vm), 32'h0000_FFFF);
    check("t3 ready mask", 32'(rm), 32'h0000_8080);
    check("t3 101 hits", 32'(hits), 32'd2);

    // 4: ch1 LSB first with gap, 01 then 80
    tick();
    ld[1] = 8'h01;
    lv[1] = 1'b1;
    tick();
    ld[1] = 8'h80;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      bv[k] = so[1];
      vv[k] = sv[1];
      if (k == 10) begin
        tick();
        lv[1] = 1'b0;
      end
    end
    check("t4 bits", 32'(bv), 32'h0004_0001);
    check("t4 valid pattern", 32'(vv), 32'h0007_F8FF);

    // 5: reset at bit 4 of FF
    tick();
    tick();
    tick();
    ld[0] = 8'hFF;
    lv[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("t5 valid after abort", 32'(sv[0]), 32'd0);
    check("t5 frame_done after abort", 32'(fdv[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    ld[0] = 8'h00;
    lv[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    nv   = 0;
    ones = 0;
    nfd  = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      nv   += int'(sv[0]);
      ones += int'(so[0]);
      nfd  += int'(fdv[0]);
    end
    check("t5 new word valid count", 32'(nv), 32'd8);
    check("t5 new word ones", 32'(ones), 32'd0);
    check("t5 new word frame_done", 32'(nfd), 32'd1);

    // 6: ch1 valid toggling with junk data during SHIFT
    tick();
    ld[1] = 8'hA5;
    lv[1] = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k < 8) bv[k] = so[1];
      tick();
      lv[1] = (k % 2 == 0);
      ld[1] = 8'($urandom);
    end
    lv[1] = 1'b0;
    check("t6 bits", 32'(bv[7:0]), 32'h0000_00A5);
    repeat (4) tick();
    @(negedge clk);
    check("t6 idle at end", 32'(sv[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
